sprite_line_eval: RTL
=====================

Name: sprite_line_eval

Overview:
- Per-scanline sprite evaluation stage, directly upstream of the PPU's per-slot x down-counters and pixel shifters.
- During horizontal blanking it scans the sprite attribute table and selects up to SLOTS sprites that cover the next scanline, fetching one pattern row for each.
- Results build up in a pending buffer. At the end of the line they are copied into the output registers and a commit pulse tells the counters and shifters to load.

Parameters:
- NUM_SPRITES, 16: attribute table entries scanned each line.
- SLOTS, 4: maximum sprites per scanline.
- SPRITE_H, 16: sprite height in lines.
- AW, 4: attribute address width, equal to clog2(NUM_SPRITES).

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- hcount  in  11  VGA horizontal counter, 0..1599.
- vcount  in  10  VGA line counter, 0..524.
- attr_addr  out  AW  attribute table read address.
- attr_rdata  in  32  attribute word; synchronous read, valid 1 cycle after attr_addr.
- pat_addr  out  8  pattern row address {pattern_idx[3:0], row[3:0]}.
- pat_rdata  in  32  pattern row: 16 pixels x 2 bits, pixel 0 in bits [1:0]; valid 1 cycle after pat_addr.
- slot_x  out  SLOTS*10  committed x per slot; slot k occupies [10k+9:10k].
- slot_row  out  SLOTS*32  committed pattern row per slot.
- slot_valid  out  SLOTS  committed slot-in-use mask.
- commit  out  1  one-cycle pulse when the slot_* outputs update.
- overflow  out  1  sticky for one line: more than SLOTS hits occurred on the committed line.

Behaviour:
- Attribute word fields: [9:0] x, [18:10] y (9-bit, 0..511), [22:19] pattern_idx, [23] enable; remaining bits reserved and ignored.
- Reset: all outputs 0, pending buffer cleared, FSM in IDLE, attr_addr=0, pat_addr=0.
- Target line: tl = (vcount==524) ? 0 : vcount+1, latched when the scan starts.
- States: IDLE, RD_ATTR, CHK, RD_PAT, STORE, DONE.
- IDLE:
  - Stay while hcount != 1280.
  - At hcount==1280: clear the pending buffer and the pending overflow flag, latch tl, set idx=0, drive attr_addr=0, go to RD_ATTR.
- RD_ATTR: wait one cycle for attribute read latency, go to CHK.
- CHK: compute d = {1'b0,tl} - {1'b0,y}, 10-bit wrapping.
  - Hit condition: enable=1, d < SPRITE_H, and tl < 480.
  - Hit and count < SLOTS: latch x, set pat_addr={pattern_idx, d[3:0]}, go to RD_PAT.
  - Hit and count == SLOTS: set pending overflow, go to DONE. Scanning stops.
  - Miss: advance to the next entry.
- RD_PAT: wait one cycle, go to STORE.
- STORE: write x and pat_rdata into pending slot[count], set pending valid[count], count++, advance to the next entry.
- Advance rule: if idx == NUM_SPRITES-1, go to DONE; otherwise idx++, drive attr_addr=idx, go to RD_ATTR.
- Priority: lower attribute index takes the lower slot index; the first SLOTS hits win.
- Timing: worst case 4 cycles per entry, 64 cycles at default parameters, well inside the 320-cycle blanking window.
- DONE: hold until hcount==1599.
- Commit at hcount==1599, in any state:
  - Copy pending x, row and valid into slot_x, slot_row and slot_valid; overflow takes the pending overflow flag.
  - Pulse commit for exactly 1 cycle; the new values are visible on the same edge the pulse asserts.
  - Return to IDLE.
- Commit during an unfinished scan: the partial result is committed and overflow is forced to 1.
- Invalid slots: slot_x and slot_row for slots with slot_valid=0 are driven to 0.
- Output stability: outputs hold their values between commits.
- Wrap-around: y values near 511 never match lines 0..15, because the 10-bit d stays at or above SPRITE_H. No vertical wrap.
- reset asserted mid-scan: immediate return to the reset state; no commit is emitted until the next full hcount==1599.

Optional Feature:
- Macro: SPRITE_FLIP_EN.
- Defined:
  - Attribute bit 24 = hflip: the stored row has its 2-bit pixel order reversed, so pixel i moves to pixel 15-i.
  - Attribute bit 25 = vflip: the row address uses SPRITE_H-1-d[3:0].
- Undefined: bits 24 and 25 are ignored; rows are stored unmodified.

Test Plan:
- Reset then idle lines, attribute table all disabled -> commit pulses once per line at hcount==1599; slot_valid=0, overflow=0.
- Entry 2 = {x=100, y=50, pattern_idx=3, en=1}, vcount=55 -> pat_addr=0x36 observed; after commit: slot_valid=0001, slot_x[9:0]=100, slot_row[31:0]=pattern word at address 0x36.
- Entries 0..5 enabled, all y=10, vcount=12 -> slots hold entries 0..3 in order, slot_valid=1111, overflow=1; entry 4 is never read after the overflow.
- vcount=524, entry at y=0 -> target line 0 matches with row 0; vcount=478 (target 479) matches y=470 row 9; vcount=479 (target 480) -> no hits.
- reset asserted at hcount=1300 mid-scan and released -> outputs zero, no commit on that line; normal commit on the following line.
- SPRITE_FLIP_EN defined, hflip set on a row of 0x0000_0001 -> committed row 0x4000_0000; vflip set with d=0 -> pat_addr row field = 15.

Source files
------------

// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: scans the attribute table during hblank and commits up to SLOTS hits at hcount==1599.
// Optional build macro SPRITE_FLIP_EN enables attribute bits 24 (hflip) and 25 (vflip).
//
// state   | meaning
// IDLE    | waiting for hcount==1280 to start a scan
// RD_ATTR | attribute read in flight
// CHK     | evaluate entry against the target line
// RD_PAT  | pattern row read in flight
// STORE   | write hit into the pending slot buffer
// DONE    | scan finished, waiting for the commit point
module sprite_line_eval #(
    parameter int NUM_SPRITES = 16,
    parameter int SLOTS       = 4,
    parameter int SPRITE_H    = 16,
    parameter int AW          = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           hcount,
    input  logic [9:0]            vcount,
    output logic [AW-1:0]         attr_addr,
    input  logic [31:0]           attr_rdata,
    output logic [7:0]            pat_addr,
    input  logic [31:0]           pat_rdata,
    output logic [SLOTS*10-1:0]   slot_x,
    output logic [SLOTS*32-1:0]   slot_row,
    output logic [SLOTS-1:0]      slot_valid,
    output logic                  commit,
    output logic                  overflow
);

    localparam int CW = $clog2(SLOTS + 1);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {
        IDLE, RD_ATTR, CHK, RD_PAT, STORE, DONE
    } state_t;

    state_t                   state_q;
    logic [AW-1:0]            idx_q;
    logic [CW-1:0]            count_q;
    logic [9:0]               tl_q;
    logic [9:0]               x_lat_q;
    logic [AW-1:0]            attr_addr_q;
    logic [7:0]               pat_addr_q;
    logic [SLOTS-1:0][9:0]    pend_x_q;
    logic [SLOTS-1:0][31:0]   pend_row_q;
    logic [SLOTS-1:0]         pend_valid_q;
    logic                     pend_ovf_q;
    logic [SLOTS-1:0][9:0]    slot_x_q;
    logic [SLOTS-1:0][31:0]   slot_row_q;
    logic [SLOTS-1:0]         slot_valid_q;
    logic                     commit_q;
    logic                     overflow_q;
    logic                     hflip_q;

    logic [9:0]               d_d;
    logic                     hit_d;
    logic [3:0]               row_sel_d;
    logic [31:0]              row_d;
    logic                     unused_attr;

    // Wrapping 10-bit difference keeps y near 511 far from lines 0..15.
    assign d_d   = tl_q - {1'b0, attr_rdata[18:10]};
    assign hit_d = attr_rdata[23] && (d_d < 10'(SPRITE_H)) && (tl_q < 10'd480);

`ifdef SPRITE_FLIP_EN
    assign row_sel_d   = attr_rdata[25] ? (4'(SPRITE_H - 1) - d_d[3:0]) : d_d[3:0];
    assign unused_attr = ^attr_rdata[31:26];
    always_comb begin
        row_d = pat_rdata;
        if (hflip_q) begin
            for (int i = 0; i < 16; i++) begin
                row_d[2*i +: 2] = pat_rdata[2*(15-i) +: 2];
            end
        end
    end
`else
    assign row_sel_d   = d_d[3:0];
    assign unused_attr = ^{attr_rdata[31:24], hflip_q};
    assign row_d       = pat_rdata;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            count_q      <= '0;
            tl_q         <= '0;
            x_lat_q      <= '0;
            attr_addr_q  <= '0;
            pat_addr_q   <= '0;
            pend_x_q     <= '0;
            pend_row_q   <= '0;
            pend_valid_q <= '0;
            pend_ovf_q   <= 1'b0;
            slot_x_q     <= '0;
            slot_row_q   <= '0;
            slot_valid_q <= '0;
            commit_q     <= 1'b0;
            overflow_q   <= 1'b0;
            hflip_q      <= 1'b0;
        end else if (hcount == 11'd1599 && state_q != IDLE) begin
            // Still IDLE here means no scan started this line (e.g. reset mid-scan), so nothing is committed.
            slot_x_q     <= pend_x_q;
            slot_row_q   <= pend_row_q;
            slot_valid_q <= pend_valid_q;
            overflow_q   <= pend_ovf_q || (state_q != DONE);
            commit_q     <= 1'b1;
            state_q      <= IDLE;
        end else begin
            commit_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hcount == 11'd1280) begin
                        pend_x_q     <= '0;
                        pend_row_q   <= '0;
                        pend_valid_q <= '0;
                        pend_ovf_q   <= 1'b0;
                        count_q      <= '0;
                        tl_q         <= (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
                        idx_q        <= '0;
                        attr_addr_q  <= '0;
                        state_q      <= RD_ATTR;
                    end
                end
                RD_ATTR: state_q <= CHK;
                CHK: begin
                    if (hit_d && count_q < CW'(SLOTS)) begin
                        x_lat_q    <= attr_rdata[9:0];
                        pat_addr_q <= {attr_rdata[22:19], row_sel_d};
                        hflip_q    <= attr_rdata[24];
                        state_q    <= RD_PAT;
                    end else if (hit_d) begin
                        pend_ovf_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (idx_q == AW'(NUM_SPRITES - 1)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q       <= idx_q + 1'b1;
                        attr_addr_q <= idx_q + 1'b1;
                        state_q     <= RD_ATTR;
                    end
                end
                RD_PAT: state_q <= STORE;
                STORE: begin
                    pend_x_q[count_q[SW-1:0]]     <= x_lat_q;
                    pend_row_q[count_q[SW-1:0]]   <= row_d;
                    pend_valid_q[count_q[SW-1:0]] <= 1'b1;
                    count_q                       <= count_q + 1'b1;
                    if (idx_q == AW'(NUM_SPRITES - 1)) begin
                        state_q <= DONE;
                    end else begin
                        idx_q       <= idx_q + 1'b1;
                        attr_addr_q <= idx_q + 1'b1;
                        state_q     <= RD_ATTR;
                    end
                end
                DONE:    state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign attr_addr  = attr_addr_q;
    assign pat_addr   = pat_addr_q;
    assign slot_x     = slot_x_q;
    assign slot_row   = slot_row_q;
    assign slot_valid = slot_valid_q;
    assign commit     = commit_q;
    assign overflow   = overflow_q;

endmodule
